// File: rtl/iomem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// iomem_arbiter
//
// Shares one iomem target between two masters (m0, m1). At most one
// transaction is in flight. Ownership is decided in IDLE with round-robin
// tie-breaking. The owner's payload is presented to the target during BUSY.
// The owner sees a single-cycle ready pulse in DONE. The target's read data
// is registered into the owner's rdata.
//
// Optional feature (macro IOMEM_ARB_TIMEOUT_EN):
//   When the macro is defined, an 8-bit wait counter aborts a BUSY phase after
//   TIMEOUT_CYCLES cycles with s_ready low. An abort returns 32'hFFFF_FFFF to
//   the owner and sets the sticky timeout_flag.
//   When the macro is undefined, BUSY waits forever and timeout_flag is tied
//   to 0.
//
// Parameters:
//   TIMEOUT_CYCLES  1..255, number of slave-wait cycles before an abort
//                   (only used with IOMEM_ARB_TIMEOUT_EN)
//
// Ports:
//   clk, resetn                rising-edge clock, synchronous active-low reset
//   m0_valid / m1_valid        master request, held until matching ready
//   m0_addr  / m1_addr         request address
//   m0_wdata / m1_wdata        request write data
//   m0_wstrb / m1_wstrb        request byte strobes
//   m0_ready / m1_ready        one-cycle completion pulse
//   m0_rdata / m1_rdata        read data, valid with the matching ready
//   s_valid, s_addr,
//   s_wdata, s_wstrb           shared target request (zero outside BUSY)
//   s_ready, s_rdata           target completion and read data
//   grant_id                   current or last owner (0 = m0, 1 = m1)
//   timeout_flag               sticky abort indicator
// -----------------------------------------------------------------------------
module iomem_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        grant_id,
    output logic        timeout_flag
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("iomem_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic        owner;
    logic        owner_next;
    logic        capture;
    logic [31:0] capture_data;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;
    logic        wait_expired;

`ifdef IOMEM_ARB_TIMEOUT_EN
    // The abort fires on the cycle that would make the count reach
    // TIMEOUT_CYCLES, so the DONE cycle follows exactly TIMEOUT_CYCLES
    // wait cycles.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt;
    logic       flag_q;

    assign wait_expired = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wait_cnt <= '0;
            flag_q   <= 1'b0;
        end else begin
            if (state != BUSY) begin
                wait_cnt <= '0;
            end else if (!s_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            // A real completion in the abort cycle wins, so no flag then.
            if (state == BUSY && !s_ready && wait_expired) begin
                flag_q <= 1'b1;
            end
        end
    end

    assign timeout_flag = flag_q;
`else
    assign wait_expired = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // Next-state, arbitration and completion capture.
    always_comb begin
        state_next   = state;
        owner_next   = owner;
        capture      = 1'b0;
        capture_data = s_rdata;
        case (state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_next = BUSY;
                    // Tie goes to whoever was not granted last; a lone
                    // requester simply wins.
                    if (m0_valid && m1_valid) begin
                        owner_next = ~owner;
                    end else begin
                        owner_next = m1_valid;
                    end
                end
            end
            BUSY: begin
                if (s_ready) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else if (wait_expired) begin
                    capture      = 1'b1;
                    capture_data = 32'hFFFF_FFFF;
                    state_next   = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            owner    <= 1'b1;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            if (capture) begin
                if (owner) begin
                    rdata1_q <= capture_data;
                end else begin
                    rdata0_q <= capture_data;
                end
            end
        end
    end

    // The target sees the owner's live payload only while BUSY.
    always_comb begin
        s_valid = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        if (state == BUSY) begin
            s_valid = 1'b1;
            if (owner) begin
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                s_wstrb = m1_wstrb;
            end else begin
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
                s_wstrb = m0_wstrb;
            end
        end
    end

    assign m0_ready = (state == DONE) && !owner;
    assign m1_ready = (state == DONE) && owner;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;
    assign grant_id = owner;

endmodule

// File: tb/tb_iomem_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for iomem_arbiter: directed scenarios followed by a
// randomized run against a transaction-timeline reference model.
module tb_iomem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic        grant_id;
    logic        timeout_flag;

    int n_checks = 0;
    int n_fail   = 0;

    iomem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant_id(grant_id), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got no end of test, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready  = 0; s_rdata = 0;
    endtask

    // Holds reset for two edges, checks the reset state, releases at a negedge.
    task automatic do_reset();
        resetn = 0;
        clear_inputs();
        repeat (2) @(negedge clk);
        check("rst_svalid", 32'(s_valid), 0);
        check("rst_ready", 32'({m1_ready, m0_ready}), 0);
        check("rst_m0_rdata", m0_rdata, 0);
        check("rst_m1_rdata", m1_rdata, 0);
        check("rst_grant", 32'(grant_id), 1);
        check("rst_flag", 32'(timeout_flag), 0);
        check("rst_saddr", s_addr, 0);
        resetn = 1;
    endtask

    // Acts as the target for one transaction: waits for s_valid (expected after
    // 'lat' cycles), keeps s_ready low for k cycles, then completes with rd.
    // Returns at the negedge of the completion (DONE) cycle.
    task automatic serve(input string tag, input logic exp_owner, input int lat, input int k,
                         input logic [31:0] rd, input logic [31:0] ea, input logic [31:0] ew,
                         input logic [3:0] es);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_valid && n < 20);
        check({tag, "_latency"}, n, lat);
        for (int j = 0; j <= k; j++) begin
            if (j > 0) @(negedge clk);
            check({tag, "_svalid"}, 32'(s_valid), 1);
            check({tag, "_grant"}, 32'(grant_id), 32'(exp_owner));
            check({tag, "_saddr"}, s_addr, ea);
            check({tag, "_swdata"}, s_wdata, ew);
            check({tag, "_swstrb"}, 32'(s_wstrb), 32'(es));
            check({tag, "_early_ready"}, 32'({m1_ready, m0_ready}), 0);
            s_ready = (j == k);
            s_rdata = (j == k) ? rd : 32'hDEAD_0000 + 32'(j);
        end
        @(negedge clk);
        s_ready = 0;
        check({tag, "_own_ready"}, 32'(exp_owner ? m1_ready : m0_ready), 1);
        check({tag, "_other_ready"}, 32'(exp_owner ? m0_ready : m1_ready), 0);
        check({tag, "_rdata"}, exp_owner ? m1_rdata : m0_rdata, rd);
        check({tag, "_done_svalid"}, 32'(s_valid), 0);
        check({tag, "_done_grant"}, 32'(grant_id), 32'(exp_owner));
    endtask

    // Reference model state for the randomized run.
    logic        vld[2];
    logic        outst[2];
    int          gap[2];
    logic [31:0] pa[2];
    logic [31:0] pw[2];
    logic [3:0]  ps[2];
    logic [31:0] rd_exp[2];
    logic        busy, own, gexp, in_busy, in_done, idle_now;
    int          g, k, cyc;
    logic [31:0] srd;
    int          pulses, flags;

    initial begin
        // Single m0 read, target answers two cycles late.
        do_reset();
        m0_valid = 1; m0_addr = 32'h0300_0000;
        serve("r032", 1'b0, 1, 2, 32'h0000_00A5, 32'h0300_0000, 32'h0, 4'h0);
        m0_valid = 0;
        @(negedge clk);
        check("r032_pulse_once", 32'(m0_ready), 0);
        check("r032_rdata_hold", m0_rdata, 32'h0000_00A5);
        check("r032_m1_rdata", m1_rdata, 0);

        // Both request from reset: m0 first, then m1.
        do_reset();
        m0_valid = 1; m0_addr = 32'h0300_0004; m0_wdata = 32'h1111_0000; m0_wstrb = 4'h1;
        m1_valid = 1; m1_addr = 32'h0300_0008; m1_wdata = 32'h2222_0000; m1_wstrb = 4'h2;
        serve("r033a", 1'b0, 1, 0, 32'hA0A0_0001, 32'h0300_0004, 32'h1111_0000, 4'h1);
        m0_valid = 0;
        serve("r033b", 1'b1, 2, 1, 32'hB0B0_0002, 32'h0300_0008, 32'h2222_0000, 4'h2);
        m1_valid = 0;
        @(negedge clk);
        check("r033_idle_ready", 32'({m1_ready, m0_ready}), 0);
        check("r033_m0_rdata", m0_rdata, 32'hA0A0_0001);
        check("r033_idle_grant", 32'(grant_id), 1);

        // Back-to-back requests from both masters alternate.
        m0_valid = 1; m1_valid = 1;
        for (int i = 0; i < 4; i++) begin
            serve("r034", 1'(i % 2), (i == 0) ? 1 : 2, i % 3, 32'hC000_0000 + 32'(i),
                  (i % 2) ? 32'h0300_0008 : 32'h0300_0004,
                  (i % 2) ? 32'h2222_0000 : 32'h1111_0000,
                  (i % 2) ? 4'h2 : 4'h1);
        end
        m0_valid = 0; m1_valid = 0;
        @(negedge clk);

        // m1 write.
        m1_valid = 1; m1_addr = 32'h0300_0010; m1_wdata = 32'h1234_5678; m1_wstrb = 4'b0011;
        serve("r035", 1'b1, 1, 1, 32'h0, 32'h0300_0010, 32'h1234_5678, 4'b0011);
        m1_valid = 0;
        @(negedge clk);
        check("r035_pulse_once", 32'(m1_ready), 0);

`ifdef IOMEM_ARB_TIMEOUT_EN
        // Completion in the abort cycle wins over the timeout.
        do_reset();
        m0_valid = 1; m0_addr = 32'h0300_0020;
        serve("prec", 1'b0, 1, 3, 32'h5A5A_0001, 32'h0300_0020, 32'h0, 4'h0);
        check("prec_flag", 32'(timeout_flag), 0);
        m0_valid = 0;
        @(negedge clk);
        m0_valid = 1;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            check("to_wait_svalid", 32'(s_valid), 1);
            check("to_wait_ready", 32'(m0_ready), 0);
            check("to_wait_flag", 32'(timeout_flag), 0);
        end
        @(negedge clk);
        check("to_ready", 32'(m0_ready), 1);
        check("to_rdata", m0_rdata, 32'hFFFF_FFFF);
        check("to_flag", 32'(timeout_flag), 1);
        check("to_svalid", 32'(s_valid), 0);
        m0_valid = 0;
        repeat (4) begin
            @(negedge clk);
            check("to_flag_sticky", 32'(timeout_flag), 1);
            check("to_pulse_once", 32'(m0_ready), 0);
        end
        m0_valid = 1;
        @(negedge clk);
        check("r037_busy", 32'(s_valid), 1);
`else
        // Without the timeout the target may stall forever.
        m0_valid = 1; m0_addr = 32'h0300_0030;
        pulses = 0; flags = 0;
        repeat (300) begin
            @(negedge clk);
            pulses += int'(m0_ready) + int'(m1_ready);
            flags  += int'(timeout_flag);
        end
        check("nto_ready_pulses", pulses, 0);
        check("nto_flag", flags, 0);
        check("nto_still_busy", 32'(s_valid), 1);
`endif

        // Reset in the middle of a transaction abandons it.
        check("r037_pre_grant", 32'(grant_id), 0);
        resetn = 0;
        @(negedge clk);
        check("r037_svalid", 32'(s_valid), 0);
        check("r037_ready", 32'({m1_ready, m0_ready}), 0);
        check("r037_grant", 32'(grant_id), 1);
        check("r037_flag", 32'(timeout_flag), 0);
        check("r037_m0_rdata", m0_rdata, 0);
        resetn = 1; m0_valid = 0;
        repeat (5) begin
            @(negedge clk);
            check("r037_no_pulse", 32'({m1_ready, m0_ready}), 0);
            check("r037_idle", 32'(s_valid), 0);
        end

        // Randomized run: masters issue requests with random gaps, the target
        // answers after 0..3 cycles and toggles s_ready randomly when idle.
        do_reset();
        busy = 0; own = 0; gexp = 1; g = 0; k = 0; cyc = 0; srd = 0;
        in_busy = 0; in_done = 0;
        for (int i = 0; i < 2; i++) begin
            vld[i] = 0; outst[i] = 0; gap[i] = $urandom_range(0, 3);
            pa[i] = 0; pw[i] = 0; ps[i] = 0; rd_exp[i] = 0;
        end
        for (int it = 0; it < 3000; it++) begin
            if (it > 0) begin
                @(negedge clk);
                cyc++;
                in_busy = busy && cyc >= g && cyc <= g + k;
                in_done = busy && cyc == g + k + 1;
                if (busy && cyc == g) gexp = own;
                if (in_done) rd_exp[own] = srd;
                check("rnd_svalid", 32'(s_valid), 32'(in_busy));
                check("rnd_m0_ready", 32'(m0_ready), 32'(in_done && !own));
                check("rnd_m1_ready", 32'(m1_ready), 32'(in_done && own));
                check("rnd_m0_rdata", m0_rdata, rd_exp[0]);
                check("rnd_m1_rdata", m1_rdata, rd_exp[1]);
                check("rnd_grant", 32'(grant_id), 32'(gexp));
                check("rnd_saddr", s_addr, in_busy ? pa[own] : 32'h0);
                check("rnd_swdata", s_wdata, in_busy ? pw[own] : 32'h0);
                check("rnd_swstrb", 32'(s_wstrb), in_busy ? 32'(ps[own]) : 32'h0);
                check("rnd_flag", 32'(timeout_flag), 0);
            end
            idle_now = !busy;
            if (in_done) begin
                outst[own] = 0; vld[own] = 0;
                gap[own] = $urandom_range(0, 3);
                busy = 0;
            end
            // Owner may withdraw valid mid-transaction; it must still complete.
            if (in_busy && vld[own] && $urandom_range(0, 7) == 0) vld[own] = 0;
            for (int i = 0; i < 2; i++) begin
                if (!outst[i]) begin
                    if (gap[i] == 0) begin
                        outst[i] = 1; vld[i] = 1;
                        pa[i] = $urandom; pw[i] = $urandom; ps[i] = 4'($urandom);
                    end else begin
                        gap[i]--;
                    end
                end
            end
            if (idle_now && (vld[0] || vld[1])) begin
                own  = (vld[0] && vld[1]) ? ~gexp : vld[1];
                busy = 1;
                g    = cyc + 1;
                k    = $urandom_range(0, 3);
                srd  = $urandom;
            end
            if (busy && cyc >= g && cyc <= g + k) begin
                s_ready = (cyc == g + k);
                s_rdata = (cyc == g + k) ? srd : $urandom;
            end else begin
                s_ready = 1'($urandom_range(0, 1));
                s_rdata = $urandom;
            end
            m0_valid = vld[0]; m0_addr = pa[0]; m0_wdata = pw[0]; m0_wstrb = ps[0];
            m1_valid = vld[1]; m1_addr = pa[1]; m1_wdata = pw[1]; m1_wstrb = ps[1];
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iomem_arbiter.md
IOMEM_ARBITER -- requirements
Module: iomem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, range 1..255: slave-wait cycles before abort (used only with IOMEM_ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports m0_valid/m1_valid  input  1  master request, held until matching ready.
REQ-005 SHALL have ports m0_addr/m1_addr  input  32, m0_wdata/m1_wdata  input  32, m0_wstrb/m1_wstrb  input  4  request payload, stable while valid.
REQ-006 SHALL have ports m0_ready/m1_ready  output  1  one-cycle completion pulse.
REQ-007 SHALL have ports m0_rdata/m1_rdata  output  32  read data, valid when matching ready is 1.
REQ-008 SHALL have ports s_valid  output  1, s_addr  output  32, s_wdata  output  32, s_wstrb  output  4  shared iomem target request.
REQ-009 SHALL have ports s_ready  input  1, s_rdata  input  32  target completion and read data.
REQ-010 SHALL have port grant_id  output  1  current or last owner (0 = m0, 1 = m1).
REQ-011 SHALL have port timeout_flag  output  1  sticky abort indicator.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE; one transaction in flight at most.
REQ-013 IDLE: if any mX_valid, SHALL latch owner and go to BUSY next cycle; else stay in IDLE.
REQ-014 Arbitration SHALL be round-robin: one requester gets the grant; with both requesting, the grant goes to the master not granted last.
REQ-015 BUSY: s_valid SHALL be 1; s_addr/s_wdata/s_wstrb SHALL be a combinational mux of the owner's payload.
REQ-016 Outside BUSY, s_valid SHALL be 0; s_addr/s_wdata/s_wstrb SHALL be 0.
REQ-017 BUSY with s_ready=1: SHALL register s_rdata into owner's rdata and go to DONE.
REQ-018 DONE: owner's mX_ready SHALL be 1 for exactly this cycle; non-owner ready SHALL be 0; next state IDLE.
REQ-019 Latency: valid sampled in IDLE at cycle t, s_valid at t+1, s_ready at t+1+k (k>=0), mX_ready at t+2+k.
REQ-020 s_ready outside BUSY SHALL be ignored.
REQ-021 A granted transaction is committed: if the owner drops valid during BUSY, it SHALL still complete and pulse ready.
REQ-022 Non-owner rdata SHALL hold its previous value.
REQ-023 A request arriving during BUSY/DONE SHALL wait; it SHALL be arbitrated in the next IDLE.
REQ-024 grant_id SHALL update on entry to BUSY and hold through DONE and IDLE.

Reset
REQ-025 With resetn=0 at a clock edge: state IDLE, m0_ready=m1_ready=0, m0_rdata=m1_rdata=0, s_valid=0, timeout_flag=0, wait counter 0.
REQ-026 grant_id SHALL reset to 1, so m0 wins the first tie.
REQ-027 Reset mid-transaction SHALL abandon it with no ready pulse.

Configuration
REQ-028 Macro IOMEM_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL count BUSY cycles with s_ready=0.
REQ-029 When the count reaches TIMEOUT_CYCLES, SHALL go to DONE, set owner rdata to 32'hFFFF_FFFF, pulse owner ready and set timeout_flag (cleared only by reset).
REQ-030 s_ready=1 in the abort cycle SHALL take precedence (normal completion).
REQ-031 Macro undefined: BUSY SHALL wait indefinitely; timeout_flag SHALL be constant 0; no counter logic.

Verification
REQ-032 m0 read at addr 32'h0300_0000, s_ready after 2 cycles, s_rdata 32'h0000_00A5 -> m0_ready one pulse at t+4, m0_rdata 32'h0000_00A5, m1_ready 0.
REQ-033 m0 and m1 both valid from reset -> m0 served first (grant_id 0), then m1 (grant_id 1); each ready pulses once.
REQ-034 Both masters hold back-to-back requests for 4 transactions -> grants alternate 0,1,0,1; s_valid 0 during every DONE.
REQ-035 m1 write wdata 32'h1234_5678, wstrb 4'b0011 -> s_wdata/s_wstrb match during BUSY; m1_ready pulses once.
REQ-036 Macro on, TIMEOUT_CYCLES=4, s_ready held 0 -> ready pulses after 4 wait cycles, rdata 32'hFFFF_FFFF, timeout_flag stays 1; macro off -> no ready pulse within 300 cycles.
REQ-037 resetn low for one cycle during BUSY -> s_valid 0 next cycle, no ready pulse, grant_id 1.
